// File: rtl/pendigits_feature_loader_pkg.sv
// rtl/pendigits_feature_loader_pkg.sv - shared classifier types and default sizes
package pendigits_feature_loader_pkg;

  localparam int DEF_NUM_FEATURES  = 16;
  localparam int DEF_FEAT_W        = 8;
  localparam int DEF_CLASS_W       = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    SETTLE,
    OUT
  } state_e;

endpackage

// File: rtl/pendigits_feature_loader_if.sv
// rtl/pendigits_feature_loader_if.sv - feature stream, tree and result signals of the loader
interface pendigits_feature_loader_if
  import pendigits_feature_loader_pkg::*;
#(
  parameter int NUM_FEATURES = DEF_NUM_FEATURES,
  parameter int FEAT_W       = DEF_FEAT_W,
  parameter int CLASS_W      = DEF_CLASS_W
);

  logic                           s_valid;
  logic                           s_ready;
  logic [FEAT_W-1:0]              s_data;
  logic                           s_last;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_vec;
  logic [CLASS_W-1:0]             class_in;
  logic                           m_valid;
  logic                           m_ready;
  logic [CLASS_W-1:0]             m_class;
  logic                           m_err;

  // slave is the loader; master is whatever drives the stream and consumes results
  modport slave (
    input  s_valid, s_data, s_last, class_in, m_ready,
    output s_ready, feat_vec, m_valid, m_class, m_err
  );

  modport master (
    output s_valid, s_data, s_last, class_in, m_ready,
    input  s_ready, feat_vec, m_valid, m_class, m_err
  );

endinterface

// File: rtl/pendigits_feature_loader.sv
// rtl/pendigits_feature_loader.sv - assembles a feature frame, waits for the tree to settle, emits its class
module pendigits_feature_loader
  import pendigits_feature_loader_pkg::*;
#(
  parameter int NUM_FEATURES  = DEF_NUM_FEATURES,
  parameter int FEAT_W        = DEF_FEAT_W,
  parameter int CLASS_W       = DEF_CLASS_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pendigits_feature_loader_if.slave    bus
);

  localparam int IDX_W = $clog2(NUM_FEATURES);
  localparam int CNT_W = $clog2(SETTLE_CYCLES) + 1;
  localparam int VEC_W = NUM_FEATURES * FEAT_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [VEC_W-1:0]   feat_q, feat_d;
  logic [CLASS_W-1:0] class_q, class_d;
  logic               merr_q, merr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      feat_q  <= '0;
      class_q <= '0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      merr_q  <= merr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    feat_d  = feat_q;
    class_d = class_q;
    merr_d  = merr_q;

    unique case (state_q)
      LOAD: begin
        if (bus.s_valid) begin
          if (idx_q == '0) begin
            err_d = 1'b0;
          end
          // Slot idx takes the beat; on a short frame the unfilled tail is zeroed on the same edge.
          for (int k = 0; k < NUM_FEATURES; k++) begin
            if (k == int'(idx_q)) begin
              feat_d[k*FEAT_W +: FEAT_W] = bus.s_data;
            end else if (bus.s_last && (k > int'(idx_q))) begin
              feat_d[k*FEAT_W +: FEAT_W] = '0;
            end
          end
          if (bus.s_last) begin
            if (idx_q != IDX_LAST) begin
              err_d = 1'b1;
            end
            state_d = SETTLE;
          end else if (idx_q == IDX_LAST) begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (bus.s_valid && bus.s_last) begin
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          class_d = bus.class_in;
          merr_d  = err_q;
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      OUT: begin
        if (bus.m_ready) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  // Both handshake outputs decode only registered state.
  assign bus.s_ready  = (state_q == LOAD) || (state_q == DRAIN);
  assign bus.m_valid  = (state_q == OUT);
  assign bus.feat_vec = feat_q;
  assign bus.m_class  = class_q;
  assign bus.m_err    = merr_q;

endmodule

// File: tb/tb_pendigits_feature_loader.sv
// tb/tb_pendigits_feature_loader.sv - directed and randomized frames checked against a frame-level model
module tb_pendigits_feature_loader;

  localparam int NF = 16;
  localparam int FW = 8;
  localparam int CW = 4;
  localparam int SC = 2;

  typedef logic [FW-1:0] beat_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pendigits_feature_loader_if #(.NUM_FEATURES(NF), .FEAT_W(FW), .CLASS_W(CW)) bus ();

  pendigits_feature_loader #(
    .NUM_FEATURES (NF),
    .FEAT_W       (FW),
    .CLASS_W      (CW),
    .SETTLE_CYCLES(SC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [NF*FW-1:0] obs, input logic [NF*FW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame-level model: first NF beats land in order, missing slots read 0, any other length is an error.
  function automatic logic [NF*FW-1:0] model_vec(input beat_q_t beats);
    logic [NF*FW-1:0] v;
    v = '0;
    for (int k = 0; k < NF; k++) begin
      if (k < beats.size()) v[k*FW +: FW] = beats[k];
    end
    return v;
  endfunction

  task automatic run_frame(input beat_q_t beats, input int gap_pct, input int bp_cycles,
                           input logic [CW-1:0] cls, input bit b2b, input logic [FW-1:0] next_first);
    logic [NF*FW-1:0] exp_vec;
    logic             exp_err;
    int               i;
    exp_vec = model_vec(beats);
    exp_err = (beats.size() != NF);
    i = 0;
    while (i < beats.size()) begin
      bus.class_in = CW'($urandom);
      if (i > 0 && $urandom_range(99) < gap_pct) begin
        bus.s_valid = 1'b0;
        step();
      end else begin
        bus.s_valid = 1'b1;
        bus.s_data  = beats[i];
        bus.s_last  = (i == beats.size() - 1);
        if (i >= NF) chk("drain_s_ready", NF*FW'(bus.s_ready), NF*FW'(1'b1));
        step();
        i++;
      end
    end
    bus.s_valid  = 1'b0;
    bus.s_last   = 1'b0;
    bus.class_in = ~cls;
    chk("settle_s_ready", NF*FW'(bus.s_ready), '0);
    step();
    chk("settle_m_valid", NF*FW'(bus.m_valid), '0);
    bus.class_in = cls;
    step();
    bus.class_in = ~cls;
    chk("out_m_valid", NF*FW'(bus.m_valid), NF*FW'(1'b1));
    chk("out_m_class", NF*FW'(bus.m_class), NF*FW'(cls));
    chk("out_m_err", NF*FW'(bus.m_err), NF*FW'(exp_err));
    chk("out_feat_vec", bus.feat_vec, exp_vec);
    for (int c = 0; c < bp_cycles; c++) begin
      bus.m_ready = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = FW'($urandom);
      bus.class_in = CW'($urandom);
      step();
      chk("bp_m_valid", NF*FW'(bus.m_valid), NF*FW'(1'b1));
      chk("bp_s_ready", NF*FW'(bus.s_ready), '0);
      chk("bp_m_class", NF*FW'(bus.m_class), NF*FW'(cls));
      chk("bp_feat_vec", bus.feat_vec, exp_vec);
    end
    bus.m_ready = 1'b1;
    bus.s_valid = b2b;
    bus.s_data  = next_first;
    bus.s_last  = 1'b0;
    step();
    chk("hs_m_valid", NF*FW'(bus.m_valid), '0);
    chk("hs_s_ready", NF*FW'(bus.s_ready), NF*FW'(1'b1));
    bus.m_ready = b2b;
  endtask

  initial begin
    beat_q_t q, nq;
    logic [CW-1:0] cls;

    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.s_last   = 1'b0;
    bus.class_in = '0;
    bus.m_ready  = 1'b0;
    step();
    step();
    chk("rst_m_valid", NF*FW'(bus.m_valid), '0);
    chk("rst_feat_vec", bus.feat_vec, '0);
    chk("rst_m_class", NF*FW'(bus.m_class), '0);
    chk("rst_m_err", NF*FW'(bus.m_err), '0);
    chk("rst_s_ready", NF*FW'(bus.s_ready), NF*FW'(1'b1));
    rst_n = 1'b1;
    step();

    // Nominal frame with 5 cycles of backpressure.
    q = {};
    for (int k = 0; k < NF; k++) q.push_back(FW'(k * 16));
    run_frame(q, 0, 5, 4'h9, 1'b0, '0);
    chk("nom_lo", NF*FW'(bus.feat_vec[7:0]), NF*FW'(8'h00));
    chk("nom_hi", NF*FW'(bus.feat_vec[127:120]), NF*FW'(8'hF0));

    // Short frame: ten beats ending in 0xAA, tail slots must be zeroed.
    q = {};
    for (int k = 0; k < 9; k++) q.push_back(FW'($urandom_range(1, 255)));
    q.push_back(8'hAA);
    run_frame(q, 0, 0, 4'h3, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("single_result_short", NF*FW'(bus.m_valid), '0);
    end

    // Long frame: 20 beats, last four dropped.
    q = {};
    for (int k = 0; k < 20; k++) q.push_back(FW'($urandom));
    run_frame(q, 0, 1, 4'hC, 1'b0, '0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("single_result_long", NF*FW'(bus.m_valid), '0);
    end

    // Reset asserted while settling discards the frame.
    q = {};
    for (int k = 0; k < NF; k++) q.push_back(FW'($urandom_range(1, 255)));
    for (int k = 0; k < NF; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = q[k];
      bus.s_last  = (k == NF - 1);
      step();
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    chk("rstmid_m_valid", NF*FW'(bus.m_valid), '0);
    chk("rstmid_feat_vec", bus.feat_vec, '0);
    chk("rstmid_m_class", NF*FW'(bus.m_class), '0);
    chk("rstmid_s_ready", NF*FW'(bus.s_ready), NF*FW'(1'b1));
    for (int c = 0; c < 4; c++) begin
      step();
      chk("rstmid_no_result", NF*FW'(bus.m_valid), '0);
    end

    // Randomized frames, back-to-back with m_ready tied high, some with gaps.
    nq = {};
    for (int k = 0; k < NF; k++) nq.push_back(FW'($urandom));
    bus.m_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int len;
      q = nq;
      len = ($urandom_range(3) == 0) ? int'($urandom_range(1, 22)) : NF;
      nq = {};
      for (int k = 0; k < len; k++) nq.push_back(FW'($urandom));
      cls = CW'($urandom);
      run_frame(q, (f % 2 == 1) ? 30 : 0, 0, cls, (f != 7), nq[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pendigits_feature_loader.md
Name: pendigits_feature_loader

Overview:
- Upstream stage of the printed decision-tree classifier.
- Takes the pendigits feature stream one 8-bit feature per beat over a valid/ready handshake and assembles a NUM_FEATURES x FEAT_W vector.
- Holds the vector stable on feat_vec while the combinational tree settles, then latches the tree's class output.
- Presents that class downstream with a valid/ready handshake and a frame-length error flag.

Parameters:
- NUM_FEATURES, 16, features per frame (pendigits X1..X16).
- FEAT_W, 8, bits per feature.
- CLASS_W, 4, width of the tree class output.
- SETTLE_CYCLES, 2, cycles feat_vec is held stable before class_in is sampled; legal range >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input feature beat valid.
- s_ready  out  1  loader accepts a beat.
- s_data  in  FEAT_W  feature value.
- s_last  in  1  marks the final feature of a frame.
- feat_vec  out  NUM_FEATURES*FEAT_W  feature k at bits [k*FEAT_W +: FEAT_W]; feature 0 is the first beat; X16 is bits [127:120].
- class_in  in  CLASS_W  combinational class from the decision tree.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_class  out  CLASS_W  latched class.
- m_err  out  1  frame length was not NUM_FEATURES.

Behaviour:
- Reset values (async, rst_n low): state=LOAD, idx=0, cnt=0, err_q=0, feat_vec=0, m_class=0, m_err=0, m_valid=0. Transfers are sampled only on rising clk edges with rst_n high. Reset mid-frame or mid-SETTLE/OUT discards everything; no partial result is emitted.
- States: LOAD, DRAIN, SETTLE, OUT.
- s_ready = 1 iff state in {LOAD, DRAIN}. m_valid = 1 iff state == OUT. No combinational path from s_valid to s_ready or from m_ready to m_valid.
- LOAD, on each accepted beat:
  - Write s_data to slot idx. If it is the first beat of the frame, err_q is cleared.
  - s_last with idx == NUM_FEATURES-1: go to SETTLE.
  - s_last with idx < NUM_FEATURES-1 (short frame): on the same edge, clear slots idx+1..NUM_FEATURES-1 to 0, set err_q, go to SETTLE.
  - No s_last with idx == NUM_FEATURES-1 (long frame): set err_q, go to DRAIN.
  - Otherwise: idx++.
- DRAIN: accept and discard beats with no slot writes. An accepted beat with s_last goes to SETTLE.
- SETTLE: feat_vec frozen, cnt increments each edge. On the edge where cnt == SETTLE_CYCLES-1: m_class <= class_in, m_err <= err_q, cnt <= 0, go to OUT.
- Latency: final beat accepted at edge t. class_in is sampled at edge t+SETTLE_CYCLES. m_valid is high from then until the handshake.
- OUT: m_class, m_err and feat_vec are held stable. On m_valid && m_ready: go to LOAD, idx <= 0. feat_vec is not cleared; slots are overwritten by the next frame. The next frame's first beat is accepted no earlier than the edge after the handshake.
- Changes on class_in outside the sample edge have no effect. s_valid gaps inside a frame are legal; idx holds.
- idx width is clog2(NUM_FEATURES). cnt width is clog2(SETTLE_CYCLES)+1. idx never wraps; overflow is handled via DRAIN.

Decomposition:
- Shared classifier package: state enum (LOAD, DRAIN, SETTLE, OUT), FEAT_W, CLASS_W, NUM_FEATURES defaults.
- Single module; no sub-module. The settle counter and slot write-enable decode are small enough to stay inline.

Test Plan:
- Reset: assert rst_n low during SETTLE, release → m_valid=0, feat_vec=0, m_class=0, s_ready=1 on the first cycle after release.
- Nominal frame: 16 beats with s_data=k*16 (0x00..0xF0), s_last on beat 16, class_in=4'h9, SETTLE_CYCLES=2 → feat_vec[127:120]=0xF0 and [7:0]=0x00. m_valid rises at edge t+2 after the last beat; m_class=9, m_err=0.
- Backpressure: hold m_ready=0 for 5 cycles with s_valid=1 → m_valid, m_class and feat_vec held; s_ready=0; no beat consumed. m_ready=1 → handshake, then LOAD.
- Short frame: s_last on beat 10 with data 0xAA → slots 10..15 = 0x00, slot 9 = 0xAA, m_err=1, exactly one result.
- Long frame: 20 beats, s_last on beat 20 → slots hold beats 0..15, beats 16..19 dropped (s_ready=1 in DRAIN), m_err=1, exactly one m_valid pulse.
- Back-to-back, class timing: m_ready tied 1, next frame ready immediately → first new beat accepted the edge after the handshake. Toggle class_in during LOAD and in the SETTLE cycle before sampling → only the value at the sample edge appears on m_class.
